// File: rtl/fconv_seq.sv
// fconv_seq: converts a 12-bit two's-complement sample into a small
// sign / 3-bit exponent / 4-bit significand code (value = f * 2^e).
// The magnitude is normalised one shift per cycle, rounded half-up on the
// first dropped bit, and saturated when the exponent no longer fits.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a sample, in_ready high
// ABS   | split sample into sign and unsigned magnitude
// NORM  | shift magnitude left until MSB set or 8 shifts done
// RND   | round, handle carry-out, saturate, register result
// DONE  | result presented, held until the consumer takes it
module fconv_seq #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [11:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_s,
  output logic [2:0]       out_e,
  output logic [3:0]       out_f,
  output logic             out_sat,
  output logic             busy,
  output logic [CNT_W-1:0] conv_cnt
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ABS  = 3'd1,
    NORM = 3'd2,
    RND  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t      state;
  logic [11:0] d_reg;
  logic [11:0] mag;
  logic        s_reg;
  logic [3:0]  k;

  logic [3:0]  e_base;
  logic [4:0]  f5;
  logic [3:0]  f_rnd;
  logic [3:0]  e_rnd;
  logic        sat;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // Rounding datapath; only consumed while in RND.
  always_comb begin
    e_base = 4'd8 - k;
    f5     = {1'b0, mag[11:8]} + {4'b0000, mag[7]};
    f_rnd  = f5[3:0];
    e_rnd  = e_base;
    // A carry out of the significand renormalises to 1000 with one more exponent step.
    if (f5[4]) begin
      f_rnd = 4'b1000;
      e_rnd = e_base + 4'd1;
    end
    sat = (e_rnd >= 4'd8);
  end

  // Conversion sequencer with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      d_reg     <= '0;
      mag       <= '0;
      s_reg     <= 1'b0;
      k         <= '0;
      out_valid <= 1'b0;
      out_s     <= 1'b0;
      out_e     <= '0;
      out_f     <= '0;
      out_sat   <= 1'b0;
      conv_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            d_reg <= in_data;
            state <= ABS;
          end
        end
        ABS: begin
          s_reg <= d_reg[11];
          // -0x800 wraps back to 0x800, which is the correct unsigned magnitude.
          mag   <= d_reg[11] ? (12'd0 - d_reg) : d_reg;
          k     <= '0;
          state <= NORM;
        end
        NORM: begin
          if (mag[11] || (k == 4'd8)) begin
            state <= RND;
          end else begin
            mag <= {mag[10:0], 1'b0};
            k   <= k + 4'd1;
          end
        end
        RND: begin
          out_s     <= s_reg;
          out_valid <= 1'b1;
          if (sat) begin
            out_e   <= 3'd7;
            out_f   <= 4'd15;
            out_sat <= 1'b1;
          end else begin
            out_e   <= e_rnd[2:0];
            out_f   <= f_rnd;
            out_sat <= 1'b0;
          end
          state <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            conv_cnt  <= conv_cnt + CNT_W'(1);
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
